// File: rtl/aibcr3_dcc_pkg.sv
// ============================================================================
// Module      : aibcr3_dcc_pkg
// Description : Shared types and constants for the DCC-bypass sequencer.
//               Holds the FSM state encoding, counter width, default hold
//               lengths and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aibcr3_dcc_pkg;

  localparam int CNT_W          = 8;
  localparam int PRE_CYC_DEF    = 4;
  localparam int SETTLE_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aibcr3_sync_ff.sv
// ============================================================================
// Module      : aibcr3_sync_ff
// Description : STAGES-deep single-bit flop synchronizer with synchronous
//               active-high reset (all stages clear to 0).
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/aibcr3_dcc_byp_seq.sv
// ============================================================================
// Module      : aibcr3_dcc_byp_seq
// Description : DCC-bypass sequencer for the RX delay-replica bank. Resolves
//               the requested bypass value and changes the replica control
//               only inside a guarded window where downstream RX data capture
//               is frozen: hold, pre-wait, switch, settle-wait, release.
// Ports       : clk              - RX core clock
//               rst              - synchronous active-high reset
//               seq_en           - allow new switch sequences
//               csr_reg6         - source select (1 core, 0 inverted DPRIO)
//               idll_core2dll_1  - core bypass request (asynchronous)
//               rb_dcc_byp_dprio - DPRIO bypass bit (quasi-static)
//               dcc_byp_sel      - registered bypass control
//               rx_data_hold     - freeze RX data capture downstream
//               sw_busy          - sequencer not idle
//               sw_done          - one-cycle pulse on sequence completion
//               sw_count         - completed switches, saturating
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_dcc_byp_seq
  import aibcr3_dcc_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   PRE_CYC     = PRE_CYC_DEF,
  parameter int   SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter logic BYP_RST     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_en,
  input  logic             csr_reg6,
  input  logic             idll_core2dll_1,
  input  logic             rb_dcc_byp_dprio,
  output logic             dcc_byp_sel,
  output logic             rx_data_hold,
  output logic             sw_busy,
  output logic             sw_done,
  output logic [CNT_W-1:0] sw_count
);

  // Elaboration-time parameter range checks.
  if (PRE_CYC < 1 || PRE_CYC > 255) begin : g_chk_pre
    $error("aibcr3_dcc_byp_seq: PRE_CYC must be in 1..255");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_chk_settle
    $error("aibcr3_dcc_byp_seq: SETTLE_CYC must be in 1..255");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_chk_sync
    $error("aibcr3_dcc_byp_seq: SYNC_STAGES must be in 2..3");
  end

  localparam logic [CNT_W-1:0] C_PRE_LOAD    = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic             w_core_sync;
  logic             w_req;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tgt;
  logic             r_sel;
  logic             r_hold;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_count;

  aibcr3_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_core_sync (
    .clk (clk),
    .rst (rst),
    .i_d (idll_core2dll_1),
    .o_q (w_core_sync)
  );

  // DPRIO bit is active-low bypass, hence the inversion.
  assign w_req = csr_reg6 ? w_core_sync : ~rb_dcc_byp_dprio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tgt   <= BYP_RST;
      r_sel   <= BYP_RST;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The target is captured once; later request changes are only
          // picked up after the sequence returns here.
          if (seq_en && (w_req != r_sel)) begin
            r_tgt   <= w_req;
            r_cnt   <= C_PRE_LOAD;
            r_hold  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_SWITCH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SWITCH: begin
          r_sel   <= r_tgt;
          r_cnt   <= C_SETTLE_LOAD;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= sat_inc(r_count);
          r_state <= ST_IDLE;
        end
        default: begin
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dcc_byp_sel  = r_sel;
  assign rx_data_hold = r_hold;
  assign sw_busy      = r_busy;
  assign sw_done      = r_done;
  assign sw_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3_dcc_byp_seq.sv
// ============================================================================
// Module      : tb_aibcr3_dcc_byp_seq
// Description : Directed self-checking bench for aibcr3_dcc_byp_seq with
//               default parameters (SYNC_STAGES=2, PRE_CYC=4, SETTLE_CYC=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aibcr3_dcc_byp_seq;

  logic       clk;
  logic       rst;
  logic       seq_en;
  logic       csr_reg6;
  logic       idll_core2dll_1;
  logic       rb_dcc_byp_dprio;
  logic       dcc_byp_sel;
  logic       rx_data_hold;
  logic       sw_busy;
  logic       sw_done;
  logic [7:0] sw_count;

  int n_pass;
  int n_total;
  int busy_bad;

  aibcr3_dcc_byp_seq dut (
    .clk              (clk),
    .rst              (rst),
    .seq_en           (seq_en),
    .csr_reg6         (csr_reg6),
    .idll_core2dll_1  (idll_core2dll_1),
    .rb_dcc_byp_dprio (rb_dcc_byp_dprio),
    .dcc_byp_sel      (dcc_byp_sel),
    .rx_data_hold     (rx_data_hold),
    .sw_busy          (sw_busy),
    .sw_done          (sw_done),
    .sw_count         (sw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples outputs on each of the next 'budget' falling edges (index 1..).
  // Optionally toggles the DPRIO bit right after sampling index flip_at.
  task automatic observe(input int budget, input int flip_at,
                         output int t_rise, output int n_hold,
                         output int t_sel, output int n_done,
                         output int t_done, output int t_fall);
    logic prev_sel;
    logic seen_hi;
    t_rise = -1; n_hold = 0; t_sel = -1; n_done = 0; t_done = -1; t_fall = -1;
    prev_sel = dcc_byp_sel;
    seen_hi  = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rx_data_hold === 1'b1) begin
        n_hold++;
        if (t_rise < 0) t_rise = i;
        seen_hi = 1'b1;
      end else if (seen_hi && t_fall < 0) begin
        t_fall = i;
      end
      if (dcc_byp_sel !== prev_sel && t_sel < 0) t_sel = i;
      prev_sel = dcc_byp_sel;
      if (sw_done === 1'b1) begin
        n_done++;
        if (t_done < 0) t_done = i;
      end
      if (sw_busy !== rx_data_hold) busy_bad++;
      if (i == flip_at) rb_dcc_byp_dprio = ~rb_dcc_byp_dprio;
    end
  endtask

  initial begin
    int tr, nh, ts, nd, td, tf;
    n_pass = 0; n_total = 0; busy_bad = 0;
    rst = 1'b1; seq_en = 1'b1; csr_reg6 = 1'b0;
    idll_core2dll_1 = 1'b0; rb_dcc_byp_dprio = 1'b0;
    wait_cyc(3);
    rst = 1'b0;

    // Reset values, then idle with req matching BYP_RST.
    chk("rst_sel",   dcc_byp_sel,  1);
    chk("rst_hold",  rx_data_hold, 0);
    chk("rst_busy",  sw_busy,      0);
    chk("rst_done",  sw_done,      0);
    chk("rst_count", sw_count,     0);
    observe(50, 0, tr, nh, ts, nd, td, tf);
    chk("idle_hold_cycles", nh, 0);
    chk("idle_done",        nd, 0);

    // DPRIO path: sel 1 -> 0.
    rb_dcc_byp_dprio = 1'b1;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("dprio_hold_rise", tr, 1);
    chk("dprio_sel_chg",   ts, 6);
    chk("dprio_hold_len",  nh, 22);
    chk("dprio_done_cnt",  nd, 1);
    chk("dprio_done_at",   td, 23);
    chk("dprio_hold_fall", tf, 23);
    chk("dprio_sel",       dcc_byp_sel, 0);
    chk("dprio_count",     sw_count,    1);

    // DPRIO back: sel 0 -> 1.
    rb_dcc_byp_dprio = 1'b0;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("dprio2_sel",   dcc_byp_sel, 1);
    chk("dprio2_count", sw_count,    2);

    // Core path: pre-set core=1 so the source swap is glitch-free.
    idll_core2dll_1 = 1'b1;
    wait_cyc(5);
    csr_reg6 = 1'b1;
    observe(10, 0, tr, nh, ts, nd, td, tf);
    chk("core_swap_quiet", tr, -1);
    // Sub-cycle glitch that no rising edge samples.
    #1 idll_core2dll_1 = 1'b0;
    #2 idll_core2dll_1 = 1'b1;
    observe(30, 0, tr, nh, ts, nd, td, tf);
    chk("core_glitch_rise", tr, -1);
    chk("core_glitch_sel",  dcc_byp_sel, 1);
    idll_core2dll_1 = 1'b0;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("core_hold_rise", tr, 3);
    chk("core_sel_chg",   ts, 8);
    chk("core_hold_len",  nh, 22);
    chk("core_done_at",   td, 25);
    chk("core_sel",       dcc_byp_sel, 0);
    chk("core_count",     sw_count,    3);
    rb_dcc_byp_dprio = 1'b1;
    wait_cyc(1);
    csr_reg6 = 1'b0;
    wait_cyc(2);
    chk("back_to_dprio_busy", sw_busy, 0);

    // Mid-sequence reversal during SETTLE.
    rb_dcc_byp_dprio = 1'b0;
    observe(60, 10, tr, nh, ts, nd, td, tf);
    chk("rev_hold_rise", tr, 1);
    chk("rev_sel_chg",   ts, 6);
    chk("rev_idle_gap",  tf, 23);
    chk("rev_hold_len",  nh, 44);
    chk("rev_done_cnt",  nd, 2);
    chk("rev_sel",       dcc_byp_sel, 0);
    chk("rev_count",     sw_count,    5);

    // seq_en low freezes; raising it starts the sequence next cycle.
    seq_en = 1'b0;
    rb_dcc_byp_dprio = 1'b0;
    observe(20, 0, tr, nh, ts, nd, td, tf);
    chk("en0_rise", tr, -1);
    chk("en0_sel",  dcc_byp_sel, 0);
    seq_en = 1'b1;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("en1_rise",  tr, 1);
    chk("en1_sel",   dcc_byp_sel, 1);
    chk("en1_count", sw_count,    6);

    // seq_en dropped mid-sequence: current one completes, no new one.
    rb_dcc_byp_dprio = 1'b1;
    wait_cyc(2);
    seq_en = 1'b0;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("endrop_sel",   dcc_byp_sel, 0);
    chk("endrop_count", sw_count,    7);
    rb_dcc_byp_dprio = 1'b0;
    observe(20, 0, tr, nh, ts, nd, td, tf);
    chk("endrop_no_new", tr, -1);
    seq_en = 1'b1;
    observe(40, 0, tr, nh, ts, nd, td, tf);
    chk("endrop_resume_sel", dcc_byp_sel, 1);

    // Reset during HOLD.
    rb_dcc_byp_dprio = 1'b1;
    wait_cyc(2);
    chk("midrst_in_hold", rx_data_hold, 1);
    rst = 1'b1;
    wait_cyc(1);
    chk("midrst_hold",  rx_data_hold, 0);
    chk("midrst_sel",   dcc_byp_sel,  1);
    chk("midrst_count", sw_count,     0);
    chk("midrst_busy",  sw_busy,      0);
    rst = 1'b0;

    // Saturation: pending sequence + 260 toggles.
    observe(30, 0, tr, nh, ts, nd, td, tf);
    chk("sat_start_count", sw_count, 1);
    for (int k = 1; k <= 259; k++) begin
      rb_dcc_byp_dprio = ~rb_dcc_byp_dprio;
      wait_cyc(30);
      if (k == 253) chk("sat_pre_count", sw_count, 254);
    end
    chk("sat_count", sw_count, 255);
    rb_dcc_byp_dprio = ~rb_dcc_byp_dprio;
    observe(30, 0, tr, nh, ts, nd, td, tf);
    chk("sat_done_pulse", nd, 1);
    chk("sat_count_hold", sw_count, 255);

    chk("busy_eq_hold", busy_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
